// File: rtl/phy_pipe_pkg.sv
// Shared PHY lane-pipeline constants and the lane-slice helper used by the
// deserialiser, retiming and un-striping blocks.
package phy_pipe_pkg;

  localparam int unsigned DefaultLanes = 2;
  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 1;

  // LSB of a lane's slice within a packed multi-lane data bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/etapaflops_elastic_if.sv
// Multi-lane data/valid bundle; the producer side uses master, the consumer slave.
interface etapaflops_elastic_if
  import phy_pipe_pkg::*;
#(
  parameter int unsigned LANES = DefaultLanes,
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic [LANES*WIDTH-1:0] data;
  logic [LANES-1:0]       valid;

  modport master (output data, output valid);
  modport slave  (input data, input valid);

endinterface

// File: rtl/etapa_lane.sv
// Single-lane elastic retiming pipeline: bubbles collapse under stall, a full lane
// drops new words and raises a sticky overflow.
module etapa_lane
  import phy_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned DEPTH     = DefaultDepth,
  parameter bit          HOLD_DATA = 1'b1
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overflow_o,
  output logic             lane_empty_o
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic             ovf_q, ovf_d;
  logic             full_above;

  // Stage k is written when its source moves: that happens unless stall is set and
  // every stage from k up to the output is already valid.
  always_comb begin
    full_above = 1'b1;
    load       = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      full_above = full_above & v_q[k];
      load[k]    = ~stall | ~full_above;
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;

    if (load[0]) begin
      v_d[0] = valid_i;
      if (valid_i) begin
        d_d[0] = data_i;
      end else if (!HOLD_DATA) begin
        d_d[0] = '0;
      end
    end

    for (int k = 1; k < DEPTH; k++) begin
      if (load[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          d_d[k] = d_q[k-1];
        end else if (!HOLD_DATA) begin
          d_d[k] = '0;
        end
      end
    end

    if (flush) begin
      v_d = '0;
      if (!HOLD_DATA) begin
        for (int k = 0; k < DEPTH; k++) begin
          d_d[k] = '0;
        end
      end
    end

    ovf_d = ovf_q | (valid_i & ~load[0] & ~flush);
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      v_q   <= '0;
      d_q   <= '{default: '0};
      ovf_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      ovf_q <= ovf_d;
    end
  end

  assign data_o       = d_q[DEPTH-1];
  assign valid_o      = v_q[DEPTH-1];
  assign overflow_o   = ovf_q;
  assign lane_empty_o = ~|v_d;

endmodule

// File: rtl/etapaflops_elastic.sv
// LANES-wide elastic retiming stage between the RX deserialisers and byte un-striping;
// lanes share only stall, flush and reset.
module etapaflops_elastic
  import phy_pipe_pkg::*;
#(
  parameter int unsigned LANES     = DefaultLanes,
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned DEPTH     = DefaultDepth,
  parameter bit          HOLD_DATA = 1'b1
) (
  input  logic                 clk_2f,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  etapaflops_elastic_if.slave  in_if,
  etapaflops_elastic_if.master out_if,
  output logic                 pipe_empty,
  output logic [LANES-1:0]     overflow
);

  logic [LANES-1:0] lane_empty;
  logic [LANES-1:0] lane_valid;
  logic [WIDTH-1:0] lane_data [LANES];
  logic             pipe_empty_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    etapa_lane #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .HOLD_DATA (HOLD_DATA)
    ) u_lane (
      .clk_2f       (clk_2f),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .data_i       (in_if.data[lane_lsb(i, WIDTH) +: WIDTH]),
      .valid_i      (in_if.valid[i]),
      .data_o       (lane_data[i]),
      .valid_o      (lane_valid[i]),
      .overflow_o   (overflow[i]),
      .lane_empty_o (lane_empty[i])
    );
  end

  always_comb begin
    out_if.data = '0;
    for (int i = 0; i < LANES; i++) begin
      out_if.data[lane_lsb(i, WIDTH) +: WIDTH] = lane_data[i];
    end
  end

  assign out_if.valid = lane_valid;

  // Registered from next-state valid bits so it lines up with valid_out.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      pipe_empty_q <= 1'b1;
    end else begin
      pipe_empty_q <= &lane_empty;
    end
  end

  assign pipe_empty = pipe_empty_q;

endmodule

// File: tb/tb_etapaflops_elastic.sv
// Three configurations (DEPTH 1/4/3, HOLD_DATA 1/1/0) driven with directed words;
// a forked monitor pops expected words whenever an output is transferred.
module tb_etapaflops_elastic;

  logic clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  logic       reset, stall, flush;
  logic       pe_a, pe_b, pe_c;
  logic [1:0] ovf_a, ovf_b, ovf_c;
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q [3][2][$];

  etapaflops_elastic_if #(.LANES(2), .WIDTH(8)) in_a  ();
  etapaflops_elastic_if #(.LANES(2), .WIDTH(8)) out_a ();
  etapaflops_elastic_if #(.LANES(2), .WIDTH(8)) in_b  ();
  etapaflops_elastic_if #(.LANES(2), .WIDTH(8)) out_b ();
  etapaflops_elastic_if #(.LANES(2), .WIDTH(8)) in_c  ();
  etapaflops_elastic_if #(.LANES(2), .WIDTH(8)) out_c ();

  etapaflops_elastic #(.LANES(2), .WIDTH(8), .DEPTH(1), .HOLD_DATA(1'b1)) u_dut_a (
    .clk_2f(clk_2f), .reset(reset), .stall(stall), .flush(flush),
    .in_if(in_a), .out_if(out_a), .pipe_empty(pe_a), .overflow(ovf_a)
  );
  etapaflops_elastic #(.LANES(2), .WIDTH(8), .DEPTH(4), .HOLD_DATA(1'b1)) u_dut_b (
    .clk_2f(clk_2f), .reset(reset), .stall(stall), .flush(flush),
    .in_if(in_b), .out_if(out_b), .pipe_empty(pe_b), .overflow(ovf_b)
  );
  etapaflops_elastic #(.LANES(2), .WIDTH(8), .DEPTH(3), .HOLD_DATA(1'b0)) u_dut_c (
    .clk_2f(clk_2f), .reset(reset), .stall(stall), .flush(flush),
    .in_if(in_c), .out_if(out_c), .pipe_empty(pe_c), .overflow(ovf_c)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got=0x%0h required=0x%0h", name, got, req);
    end
  endtask

  task automatic drive(input int di, input logic [1:0] v, input logic [15:0] d);
    case (di)
      0:       begin in_a.valid = v; in_a.data = d; end
      1:       begin in_b.valid = v; in_b.data = d; end
      default: begin in_c.valid = v; in_c.data = d; end
    endcase
  endtask

  task automatic push(input int di, input int l, input logic [7:0] w);
    exp_q[di][l].push_back(w);
  endtask

  task automatic step();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic mon_dut(input int di, input logic [1:0] v, input logic [15:0] d);
    logic [7:0] got, req;
    for (int l = 0; l < 2; l++) begin
      if (v[l]) begin
        got = d[l*8 +: 8];
        checks++;
        if (exp_q[di][l].size() == 0) begin
          failures++;
          $display("FAIL mon_dut%0d_lane%0d: got=0x%0h required=no word", di, l, got);
        end else begin
          req = exp_q[di][l].pop_front();
          if (got !== req) begin
            failures++;
            $display("FAIL mon_dut%0d_lane%0d: got=0x%0h required=0x%0h", di, l, got, req);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(0, 2'b00, 16'h0);
    drive(1, 2'b00, 16'h0);
    drive(2, 2'b00, 16'h0);

    fork
      forever begin
        @(negedge clk_2f);
        if (!reset && !stall) begin
          mon_dut(0, out_a.valid, out_a.data);
          mon_dut(1, out_b.valid, out_b.data);
          mon_dut(2, out_c.valid, out_c.data);
        end
      end
    join_none

    step();
    step();
    check("rst_valid_a", 32'(out_a.valid), 0);
    check("rst_valid_b", 32'(out_b.valid), 0);
    check("rst_data_b", 32'(out_b.data), 0);
    check("rst_empty_a", 32'(pe_a), 1);
    check("rst_empty_c", 32'(pe_c), 1);
    check("rst_ovf_b", 32'(ovf_b), 0);
    reset = 1'b0;

    // DEPTH=1 plain flop behaviour
    drive(0, 2'b11, {8'h11, 8'hA5});
    push(0, 0, 8'hA5);
    push(0, 1, 8'h11);
    step();
    check("t1_valid_e1", 32'(out_a.valid), 2'b11);
    check("t1_data_e1", 32'(out_a.data), 16'h11A5);
    check("t1_empty_e1", 32'(pe_a), 0);
    drive(0, 2'b01, {8'h00, 8'h3C});
    push(0, 0, 8'h3C);
    step();
    check("t1_valid_e2", 32'(out_a.valid), 2'b01);
    check("t1_data0_e2", 32'(out_a.data[7:0]), 8'h3C);
    check("t1_empty_e2", 32'(pe_a), 0);
    drive(0, 2'b00, 16'h0);
    step();
    check("t1_valid_e3", 32'(out_a.valid), 0);
    check("t1_empty_e3", 32'(pe_a), 1);
    check("t1_hold_e3", 32'(out_a.data[7:0]), 8'h3C);

    // HOLD_DATA=1: last word stays on data_out while idle
    drive(0, 2'b01, {8'h00, 8'h55});
    push(0, 0, 8'h55);
    step();
    check("t6_valid", 32'(out_a.valid), 2'b01);
    drive(0, 2'b00, 16'h0);
    repeat (3) step();
    check("t6_idle_valid", 32'(out_a.valid), 0);
    check("t6_idle_data", 32'(out_a.data[7:0]), 8'h55);
    drive(0, 2'b01, {8'h00, 8'h66});
    push(0, 0, 8'h66);
    step();
    check("t6_next_data", 32'(out_a.data[7:0]), 8'h66);
    drive(0, 2'b00, 16'h0);
    step();

    // DEPTH=4: bubbles collapse under stall
    drive(1, 2'b01, 16'h0001);
    push(1, 0, 8'h01);
    step();
    drive(1, 2'b00, 16'h0);
    step();
    drive(1, 2'b01, 16'h0002);
    push(1, 0, 8'h02);
    step();
    drive(1, 2'b00, 16'h0);
    step();
    check("t2_first_out", 32'(out_b.data[7:0]), 8'h01);
    stall = 1'b1;
    repeat (6) step();
    check("t2_stall_valid", 32'(out_b.valid), 2'b01);
    check("t2_stall_data", 32'(out_b.data[7:0]), 8'h01);
    check("t2_stall_empty", 32'(pe_b), 0);
    stall = 1'b0;
    step();
    check("t2_rel_valid", 32'(out_b.valid), 2'b01);
    check("t2_rel_data", 32'(out_b.data[7:0]), 8'h02);
    step();
    check("t2_drained", 32'(out_b.valid), 0);
    check("t2_drained_empty", 32'(pe_b), 1);

    // DEPTH=4: lane1 overflow under stall, sticky through flush
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b10, {8'h10 + 8'(i), 8'h00});
      if (i < 4) push(1, 1, 8'h10 + 8'(i));
      step();
    end
    check("t3_ovf", 32'(ovf_b), 2'b10);
    check("t3_valid", 32'(out_b.valid), 2'b10);
    check("t3_head", 32'(out_b.data[15:8]), 8'h10);
    drive(1, 2'b00, 16'h0);
    stall = 1'b0;
    repeat (5) step();
    check("t3_drained", 32'(out_b.valid), 0);
    check("t3_ovf_kept", 32'(ovf_b), 2'b10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t3_ovf_flush", 32'(ovf_b), 2'b10);
    check("t3_empty_flush", 32'(pe_b), 1);

    // DEPTH=3, HOLD_DATA=0: mid-stream flush
    drive(2, 2'b11, {8'h31, 8'h21});
    push(2, 0, 8'h21);
    push(2, 1, 8'h31);
    step();
    drive(2, 2'b11, {8'h32, 8'h22});
    step();
    check("t4_not_yet", 32'(out_c.valid), 0);
    drive(2, 2'b11, {8'h33, 8'h23});
    step();
    check("t4_pre_valid", 32'(out_c.valid), 2'b11);
    check("t4_pre_data", 32'(out_c.data), 16'h3121);
    flush = 1'b1;
    drive(2, 2'b11, {8'h3F, 8'h2F});
    step();
    flush = 1'b0;
    drive(2, 2'b00, 16'h0);
    check("t4_valid", 32'(out_c.valid), 0);
    check("t4_data_zero", 32'(out_c.data), 0);
    check("t4_empty", 32'(pe_c), 1);
    check("t4_no_ovf", 32'(ovf_c), 0);
    repeat (4) step();
    check("t4_stays_empty", 32'(out_c.valid), 0);

    // DEPTH=4: reset during stall with full lanes
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b11, {8'h50 + 8'(i), 8'h40 + 8'(i)});
      step();
    end
    check("t5_ovf", 32'(ovf_b), 2'b11);
    check("t5_full_valid", 32'(out_b.valid), 2'b11);
    reset = 1'b1;
    drive(1, 2'b00, 16'h0);
    step();
    check("t5_rst_valid", 32'(out_b.valid), 0);
    check("t5_rst_data", 32'(out_b.data), 0);
    check("t5_rst_ovf", 32'(ovf_b), 0);
    check("t5_rst_empty", 32'(pe_b), 1);
    reset = 1'b0;
    stall = 1'b0;
    drive(1, 2'b01, 16'h007E);
    push(1, 0, 8'h7E);
    step();
    drive(1, 2'b00, 16'h0);
    check("t5_lat1", 32'(out_b.valid), 0);
    step();
    step();
    check("t5_lat3", 32'(out_b.valid), 0);
    step();
    check("t5_lat4_valid", 32'(out_b.valid), 2'b01);
    check("t5_lat4_data", 32'(out_b.data[7:0]), 8'h7E);
    repeat (3) step();

    for (int di = 0; di < 3; di++) begin
      for (int l = 0; l < 2; l++) begin
        check($sformatf("drain_dut%0d_lane%0d", di, l), 32'(exp_q[di][l].size()), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/etapaflops_elastic.md
Name: etapaflops_elastic

Overview:
- Parametrised successor to the fixed two-lane PHY retiming stage.
- Registers LANES independent data/valid lanes through a DEPTH-deep pipeline on clk_2f.
- Adds global stall with per-lane bubble collapsing, flush, and per-lane sticky overflow detection.
- Sits between the RX lane deserialisers and the byte un-striping logic. It absorbs downstream back-pressure without losing words until a lane's pipeline is full.

Parameters:
- LANES, 2, number of independent lanes (>=1).
- WIDTH, 8, data bits per lane (>=1).
- DEPTH, 1, pipeline stages per lane (>=1); DEPTH=1 with stall tied low behaves as a plain flop stage.
- HOLD_DATA, 1, 1: data_out holds the last valid word while valid_out=0; 0: data_out forced to zero while valid_out=0.

Ports:
- clk_2f  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  downstream not accepting; the output stage holds.
- flush  in  1  synchronous clear of all pipeline contents.
- data_in  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- valid_in  in  LANES  per-lane input qualifier.
- data_out  out  LANES*WIDTH  registered output word per lane, same packing as data_in.
- valid_out  out  LANES  registered per-lane output qualifier.
- pipe_empty  out  1  registered; 1 when no stage in any lane holds a valid word.
- overflow  out  LANES  sticky; lane dropped a valid input word.

Behaviour:
- Per lane, stages S[0..DEPTH-1]. Each stage holds {v, d}. S[DEPTH-1] drives data_out/valid_out directly, so there is no combinational path from inputs to outputs.
- Move rule, per lane:
  - move[DEPTH-1] = !stall.
  - move[k] = !v[k+1] | move[k+1].
  - accept = !v[0] | move[0].
- When stage k moves:
  - S[k+1] takes S[k].
  - S[k] takes S[k-1], or the input for k=0, if that source moves or is accepted.
  - Otherwise v[k] <= 0.
- A stage that does not move holds its contents.
- No stall: latency is exactly DEPTH cycles from the sampling edge of valid_in to valid_out. Throughput is 1 word/cycle/lane.
- Stall: invalid stages (bubbles) are squeezed out; upstream valid words keep advancing until they pack against the output stage.
- Lane full (all v=1) with stall=1 and valid_in[i]=1:
  - The word is dropped.
  - overflow[i] <= 1 and stays set until reset. flush does not clear it.
  - Other lanes are unaffected.
- valid_in[i]=0 while accepted: a bubble (v=0) enters S[0]. It is not an error.
- Invalid stage data:
  - HOLD_DATA=1: d retains its previous value, so data_out holds the last valid word.
  - HOLD_DATA=0: d is cleared to 0 when v is cleared.
- flush=1 (and reset=0):
  - Next edge, all v <= 0 in all lanes.
  - Input that cycle is discarded; no overflow is raised.
  - Data follows the HOLD_DATA rule.
  - pipe_empty <= 1.
- reset=1: all v, d, overflow <= 0; pipe_empty <= 1. Reset overrides flush and stall.
- Reset mid-stall discards all buffered words. The first accepted input after reset appears DEPTH cycles later if stall=0.
- pipe_empty is computed from the next-state v bits of all lanes and registered, so it is consistent with valid_out in the same cycle.
- Lanes are fully independent except for the shared stall, flush and reset.

Decomposition:
- Package phy_pipe_pkg holds the default LANES/WIDTH/DEPTH constants shared with the deserialiser and un-striping blocks. It also holds the lane-slice index function.
- One sub-module, etapa_lane: a single-lane elastic pipeline (WIDTH, DEPTH, HOLD_DATA). Its ports are stall, flush, reset, input and output pair, overflow and lane_empty.
- The top generates LANES instances and ANDs lane_empty into pipe_empty.

Test Plan:
1. Defaults, stall=0, lane0 sends 0xA5, 0x3C on consecutive cycles, lane1 sends 0x11 → valid_out, data_out identical to the inputs after 1 cycle; pipe_empty=0 while words are in flight.
2. DEPTH=4, LANES=2:
   - Lane0 word sequence 1,-,2,- (bubbles), then stall=1 for 6 cycles.
   - Required: words 1 and 2 packed in S3/S2 with valid_out held on 1.
   - After release: 1 then 2 on consecutive cycles.
3. DEPTH=4, stall=1, lane1 fed 5 consecutive valid words 0x10..0x14 → first 4 retained; 0x14 dropped; overflow=2'b10 from the next edge and persistent through a later flush.
4. DEPTH=3, mid-stream flush=1 with valid_in=2'b11 → next cycle valid_out=0, pipe_empty=1. With HOLD_DATA=0, data_out=0; the flushed-cycle input never appears.
5. Reset asserted during stall with full lanes and overflow set → next edge all outputs 0, pipe_empty=1; after release a word 0x7E emerges DEPTH cycles later.
6. HOLD_DATA=1, lane0 sends 0x55 then idles → data_out stays 0x55 with valid_out=0 until the next valid word arrives.
